a_loader: RTL and testbench

- Upstream feeder for the matrix store of the SVD datapath.
- Accepts matrix A one element per beat over a valid/ready stream, in column-major order.
- Packs each pair of adjacent columns (c, c+1) into one 2-column bus word.
- Issues one column-mode write per pair to the store, then pulses done so the bidiagonalisation controller can start.

---
 rtl/svd_pkg.sv | 28 ++
 rtl/a_loader_sat.sv | 31 +++
 rtl/a_loader.sv | 151 +++++++++++++++
 tb/tb_a_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/svd_pkg.sv
// Shared constants, store address layout and loader FSM states for the SVD datapath.
package svd_pkg;

  localparam int DATA_W    = 24;
  localparam int ROW_LOG2  = 3;
  localparam int COL_LOG2  = 2;
  localparam int LANE_LOG2 = 3;
  localparam int ADDR_W    = 6;
  localparam int IN_W      = 28;

  // Store address: {RCn, row[2:0], col[1:0]}
  localparam int RCN_BIT = 5;
  localparam int ROW_MSB = 4;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  localparam logic RCN_COL = 1'b0;
  localparam logic RCN_ROW = 1'b1;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/a_loader_sat.sv
// Combinational signed saturator from in_width down to data_width, with a clamp indicator.
module a_loader_sat #(
  parameter int in_width   = 28,
  parameter int data_width = 24
) (
  input  logic [in_width-1:0]   din_i,
  output logic [data_width-1:0] dout_o,
  output logic                  sat_o
);

  localparam logic signed [in_width-1:0] SAT_MAX =
    {{(in_width-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
  localparam logic signed [in_width-1:0] SAT_MIN =
    {{(in_width-data_width+1){1'b1}}, {(data_width-1){1'b0}}};

  logic signed [in_width-1:0] din_s;
  assign din_s = $signed(din_i);

  always_comb begin
    dout_o = din_i[data_width-1:0];
    sat_o  = 1'b0;
    if (din_s > SAT_MAX) begin
      dout_o = {1'b0, {(data_width-1){1'b1}}};
      sat_o  = 1'b1;
    end else if (din_s < SAT_MIN) begin
      dout_o = {1'b1, {(data_width-1){1'b0}}};
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/a_loader.sv
// Streams matrix A column-major into 2-column store words, one column-mode write per pair.
// Define A_LOADER_SAT_EN for wide signed input with saturation and a sticky sat_flag.
//
// state    | meaning
// LD_IDLE  | waiting for start
// LD_LOAD  | accepting 16 elements of the current column pair into the pack register
// LD_WRITE | one-cycle column-mode store write of the pack register
// LD_DONE  | one-cycle done pulse
module a_loader
  import svd_pkg::*;
#(
  parameter int data_width        = DATA_W,
  parameter int no_of_row         = ROW_LOG2,
  parameter int no_of_col         = COL_LOG2,
  parameter int max_no_of_row_col = LANE_LOG2,
`ifdef A_LOADER_SAT_EN
  parameter int in_width          = IN_W,
`endif
  parameter int addr_width        = ADDR_W
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic                                         s_valid,
  output logic                                         s_ready,
`ifdef A_LOADER_SAT_EN
  input  logic [in_width-1:0]                          s_data,
  output logic                                         sat_flag,
`else
  input  logic [data_width-1:0]                        s_data,
`endif
  output logic                                         st_we,
  output logic [addr_width-1:0]                        st_addr,
  output logic [2*data_width*(2**max_no_of_row_col)-1:0] st_data,
  output logic                                         busy,
  output logic                                         done
);

  localparam int LANES     = 2**max_no_of_row_col;
  localparam int BUS_W     = 2*data_width*LANES;
  localparam int CNT_W     = max_no_of_row_col + 1;
  localparam logic [no_of_col-1:0] LAST_BASE = no_of_col'((2**no_of_col) - 2);

  ld_state_e              state_q, state_d;
  logic [CNT_W-1:0]       elem_cnt_q, elem_cnt_d;
  logic [no_of_col-1:0]   col_base_q, col_base_d;
  logic [BUS_W-1:0]       pack_q, pack_d;
  logic [addr_width-1:0]  addr_hold_q;
  logic [BUS_W-1:0]       data_hold_q;
  logic [addr_width-1:0]  wr_addr;
  logic [data_width-1:0]  elem;
  logic                   xfer;

`ifdef A_LOADER_SAT_EN
  logic sat_w;
  logic sat_q, sat_d;

  a_loader_sat #(
    .in_width   (in_width),
    .data_width (data_width)
  ) u_sat (
    .din_i  (s_data),
    .dout_o (elem),
    .sat_o  (sat_w)
  );

  assign sat_flag = sat_q;
`else
  assign elem = s_data;
`endif

  // Row bits are always zero: a column-mode write addresses the whole pair.
  assign wr_addr = {RCN_COL, {no_of_row{1'b0}}, col_base_q};

  assign s_ready = (state_q == LD_LOAD);
  assign xfer    = s_valid && s_ready;
  assign busy    = (state_q == LD_LOAD) || (state_q == LD_WRITE);
  assign done    = (state_q == LD_DONE);
  assign st_we   = (state_q == LD_WRITE);
  assign st_addr = st_we ? wr_addr : addr_hold_q;
  assign st_data = st_we ? pack_q  : data_hold_q;

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    col_base_d = col_base_q;
    pack_d     = pack_q;
`ifdef A_LOADER_SAT_EN
    sat_d      = sat_q;
`endif
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d    = LD_LOAD;
          elem_cnt_d = '0;
          col_base_d = '0;
`ifdef A_LOADER_SAT_EN
          sat_d      = 1'b0;
`endif
        end
      end
      LD_LOAD: begin
        if (xfer) begin
          // {h, r} counts lanes 0..15, so the lane offset is just elem_cnt * width.
          pack_d[int'(elem_cnt_q)*data_width +: data_width] = elem;
          elem_cnt_d = elem_cnt_q + CNT_W'(1);
`ifdef A_LOADER_SAT_EN
          if (sat_w) sat_d = 1'b1;
`endif
          if (elem_cnt_q == {CNT_W{1'b1}}) state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (col_base_q == LAST_BASE) begin
          state_d = LD_DONE;
        end else begin
          col_base_d = col_base_q + no_of_col'(2);
          elem_cnt_d = '0;
          state_d    = LD_LOAD;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LD_IDLE;
      elem_cnt_q  <= '0;
      col_base_q  <= '0;
      pack_q      <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
`ifdef A_LOADER_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      col_base_q  <= col_base_d;
      pack_q      <= pack_d;
      addr_hold_q <= st_addr;
      data_hold_q <= st_data;
`ifdef A_LOADER_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_a_loader.sv
// Directed, table-driven bench for a_loader; also covers the A_LOADER_SAT_EN build.
module tb_a_loader;

  localparam int DW = 24;
  localparam int BW = 2*DW*8;
`ifdef A_LOADER_SAT_EN
  localparam int IW = 28;
`else
  localparam int IW = 24;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [IW-1:0] s_data = '0;
  logic          s_ready;
  logic          st_we;
  logic [5:0]    st_addr;
  logic [BW-1:0] st_data;
  logic          busy;
  logic          done;
`ifdef A_LOADER_SAT_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  a_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
`ifdef A_LOADER_SAT_EN
    .sat_flag (sat_flag),
`endif
    .st_we    (st_we),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Write / done monitor
  int            cyc = 0;
  logic [5:0]    wr_addr[$];
  logic [BW-1:0] wr_data[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            rdy_in_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (st_we) begin
      wr_addr.push_back(st_addr);
      wr_data.push_back(st_data);
      if (s_ready) rdy_in_wr++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic [3:0]  pat;       // s_valid pattern, bit i used on cycle i mod 4
    logic [23:0] base;      // element k carries base+k
    int          start_at;  // extra start pulse after this many beats, -1 none
    int          exp_lat;   // cycles start->done, 0 = not checked
  } vec_t;

  vec_t          vecs[5];
  logic [IW-1:0] elems[32];
  int            st_cyc;

  function automatic logic [BW-1:0] exp_word(input logic [23:0] base, input int pair);
    logic [BW-1:0] w;
    w = '0;
    for (int r = 0; r < 8; r++) begin
      w[r*DW +: DW]       = base + 24'(pair*16 + r);
      w[192 + r*DW +: DW] = base + 24'(pair*16 + 8 + r);
    end
    return w;
  endfunction

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt  = 0;
    rdy_in_wr = 0;
  endtask

  task automatic drive(input logic [3:0] pat, input int start_at, input int stop_after,
                       output int k_out);
    int   k = 0;
    int   ph = 0;
    int   guard = 0;
    logic rdy = 1'b0;
    logic inj = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    st_cyc = cyc;
    while (guard < 300) begin
      if (guard > 0) start = 1'b0;
      if (s_valid && rdy) k++;
      if (k == stop_after) break;
      if (k == start_at && !inj) begin
        start = 1'b1;
        inj   = 1'b1;
      end
      s_valid = pat[ph % 4];
      ph++;
      s_data = elems[k];
      rdy    = s_ready;
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (k != stop_after) begin
      total++;
      bad++;
      $display("FAIL drive_timeout: got %0d beats want %0d", k, stop_after);
    end
    k_out = k;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_case(input int idx);
    vec_t v;
    int   k;
    v = vecs[idx];
    clear_mon();
    for (int i = 0; i < 32; i++) begin
      logic [23:0] e;
      e = v.base + 24'(i);
      elems[i] = IW'($signed(e));
    end
    drive(v.pat, v.start_at, 32, k);
    wait_done();
    chk($sformatf("v%0d_nwr", idx), 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      chk($sformatf("v%0d_addr0", idx), 64'(wr_addr[0]), 64'h00);
      chk($sformatf("v%0d_addr1", idx), 64'(wr_addr[1]), 64'h02);
      chk_bus($sformatf("v%0d_data0", idx), wr_data[0], exp_word(v.base, 0));
      chk_bus($sformatf("v%0d_data1", idx), wr_data[1], exp_word(v.base, 1));
    end
    chk($sformatf("v%0d_done_cnt", idx), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d_ready_in_write", idx), 64'(rdy_in_wr), 64'd0);
    if (v.exp_lat != 0)
      chk($sformatf("v%0d_latency", idx), 64'(done_cyc - st_cyc), 64'(v.exp_lat));
    chk($sformatf("v%0d_busy_after", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d_hold_addr", idx), 64'(st_addr), 64'h02);
    chk_bus($sformatf("v%0d_hold_data", idx), st_data, exp_word(v.base, 1));
  endtask

  initial begin
    int k;
    int idle_bad;

    vecs[0] = '{4'b1111, 24'h000000, -1, 35};
    vecs[1] = '{4'b1001, 24'h000000, -1, 0};
    vecs[2] = '{4'b1111, 24'h000000, 5, 35};
    vecs[3] = '{4'b1111, 24'hFFFFF0, -1, 35};
    vecs[4] = '{4'b0101, 24'h7FFFF0, -1, 0};

    repeat (3) @(negedge clk);
    chk("rst_we", 64'(st_we), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(st_addr), 64'd0);
    chk_bus("rst_data", st_data, '0);
    rst_n = 1'b1;

    // Idle: valid without start must not be accepted
    clear_mon();
    idle_bad = 0;
    s_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready || st_we || done || busy) idle_bad++;
    end
    s_valid = 1'b0;
    chk("idle_activity", 64'(idle_bad), 64'd0);
    chk("idle_writes", 64'(wr_addr.size()), 64'd0);

    for (int i = 0; i < 5; i++) run_case(i);

    // Reset after 20 beats: no second write, busy drops, fresh load works
    clear_mon();
    for (int i = 0; i < 32; i++) elems[i] = IW'(i);
    drive(4'b1111, -1, 20, k);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (30) @(negedge clk);
    chk("midrst_nwr", 64'(wr_addr.size()), 64'd1);
    chk("midrst_done", 64'(done_cnt), 64'd0);
    run_case(0);

`ifdef A_LOADER_SAT_EN
    chk("sat_clear", 64'(sat_flag), 64'd0);
    clear_mon();
    for (int i = 0; i < 32; i++) elems[i] = '0;
    elems[0] = 28'h0800000;
    elems[1] = 28'hF7FFFFF;
    elems[2] = 28'h0000123;
    drive(4'b1111, -1, 32, k);
    wait_done();
    chk("sat_nwr", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() >= 1) begin
      chk("sat_pos", 64'(wr_data[0][23:0]), 64'h7FFFFF);
      chk("sat_neg", 64'(wr_data[0][47:24]), 64'h800000);
      chk("sat_pass", 64'(wr_data[0][71:48]), 64'h000123);
    end
    chk("sat_flag_set", 64'(sat_flag), 64'd1);
    run_case(3);
    chk("sat_flag_cleared", 64'(sat_flag), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
